nmc_sram_arbiter: RTL and testbench
===================================

Name: nmc_sram_arbiter

Overview:
- Shares one near-memory-compute SRAM (512-bit words, 9-bit word address) between two Avalon-MM requesters: N=0 is the HPS bridge and N=1 is the FPGA DMA.
- Sequences normal reads and writes, plus accumulate writes (address bit 63 set). An accumulate write is a read-modify-write that adds sixteen 32-bit lanes.
- Round-robin arbitration with Avalon lock support.
- Sits between the interconnect and the SRAM macro (1-cycle registered read).

Parameters:
- DATA_W, 512, SRAM/Avalon data width; multiple of LANE_W.
- LANE_W, 32, accumulate lane width.
- SRAM_AW, 9, SRAM word-address width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- avsN_address  in  64  word address; bit 63 = accumulate flag (N=0,1, each port replicated per requester)
- avsN_read  in  1  read request
- avsN_write  in  1  write request
- avsN_byteenable  in  DATA_W/8  byte enables
- avsN_writedata  in  DATA_W  write data / addend
- avsN_lock  in  1  hold grant after this transfer
- avsN_readdata  out  DATA_W  read data, valid when read && !waitrequest
- avsN_waitrequest  out  1  transfer stalled
- sram_addr  out  SRAM_AW  = granted address[SRAM_AW-1:0]
- sram_byteenable  out  DATA_W/8  write byte enables, zero unless writing
- sram_writedata  out  DATA_W  write data
- sram_wren  out  1  write strobe
- sram_readdata  in  DATA_W  data for the address presented in the previous cycle

Behaviour:
- Reset: FSM=IDLE, rr_last=1 (requester 0 wins first), lock_owner=none, sram_wren=0, sram_byteenable=0, sram_addr=0, both waitrequest=1, both readdata=0.
- A request from requester N is read|write. Read and write asserted together is illegal; a write takes priority.
- Arbitration (IDLE only):
  - If lock_owner is set, only that requester is eligible.
  - Otherwise a single requester wins; if both request, the one != rr_last wins.
  - The winner index is registered as grant; rr_last is updated when the transfer completes.
  - The non-granted requester sees waitrequest=1 throughout.
- FSM states: IDLE, RD, ACC_RD, ACC_WR.
  - IDLE, normal write: sram_wren=1, byteenable passed, winner waitrequest=0 in the same cycle (0 wait states). Stay in IDLE.
  - IDLE, read: drive sram_addr, go to RD.
  - IDLE, accumulate write: drive sram_addr, wren=0, go to ACC_RD.
  - RD: avsN_readdata=sram_readdata, waitrequest=0 → IDLE. Read latency is 2 cycles total.
  - ACC_RD: capture sram_readdata into acc_reg, → ACC_WR.
  - ACC_WR: sram_writedata[i]=avs writedata lane i + acc_reg lane i for all 16 lanes; sram_wren=1 with byteenable passed; waitrequest=0 → IDLE. Total 3 cycles.
- Lane arithmetic: unsigned modulo 2^LANE_W (carry dropped), no cross-lane carry. Byte-enabled-off bytes are not written.
- Master signals must stay stable while waitrequest=1. The arbiter samples address and writedata in IDLE and holds them in a register for RD/ACC_*.
- Lock:
  - Completing a transfer with lock=1 sets lock_owner=N.
  - Completing one with lock=0 clears it.
  - If the owner deasserts both read and write, lock is retained until its next completed transfer.
- Back-to-back: a new request is accepted in the IDLE cycle following completion; no bubble is required beyond the return to IDLE.
- Reset mid-operation: FSM → IDLE, with no SRAM write issued. An interrupted accumulate is lost, and its master sees the reset waitrequest=1.

Optional Feature:
- Macro NMC_ACC_SATURATE_EN.
- Defined: lane add is signed two's-complement saturating. Results clamp to 0x7FFFFFFF / 0x80000000 on overflow, and a sticky acc_sat_o output (1 bit, reset 0, cleared only by reset) is added.
- Undefined: modulo add, no acc_sat_o port.

Decomposition:
- Package nmc_pkg:
  - state enum {IDLE,RD,ACC_RD,ACC_WR}
  - constants ACC_FLAG_BIT=63, NUM_LANES=DATA_W/LANE_W, NUM_REQ=2
- One sub-module, nmc_lane_adder: a combinational per-lane adder, instantiated NUM_LANES times, with the saturating variant under the macro.

Test Plan:
- Single write: requester 0 writes 0xA5 pattern at address 5, be=all-ones → sram_wren=1 in the same cycle, waitrequest0=0, no stall.
- Read: requester 1 reads address 5 after the previous write → readdata1=0xA5 pattern at cycle 2, waitrequest1 high for exactly 1 cycle.
- Accumulate write:
  - Setup: address 3 holds lane value 0x00000010 in every lane; write address {1'b1,…,3} data 0x00000005 per lane.
  - Result: address 3 reads back 0x15 in every lane; 3-cycle transfer.
  - Wrap check: 0xFFFFFFFF + 1 → 0 (macro off); with NMC_ACC_SATURATE_EN, 0x7FFFFFFF+1 → 0x7FFFFFFF and acc_sat_o=1.
- Contention: both requesters issue continuous reads → grants alternate 0,1,0,1; no starvation over 20 transfers.
- Lock: requester 1 issues 3 writes with lock=1,1,0 while requester 0 requests → requester 0 is served only after the third write.
- Reset asserted during ACC_RD → no sram_wren pulse, both waitrequest=1, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/nmc_sram_arbiter_pkg.sv
// Shared types and constants for the near-memory-compute SRAM arbiter.
package nmc_pkg;
    typedef enum logic [1:0] {IDLE, RD, ACC_RD, ACC_WR} state_e;

    localparam int ACC_FLAG_BIT = 63;
    localparam int DATA_W_DEF   = 512;
    localparam int LANE_W_DEF   = 32;
    localparam int NUM_LANES    = DATA_W_DEF / LANE_W_DEF;
    localparam int NUM_REQ      = 2;
endpackage

// File: rtl/nmc_sram_arbiter_lane_adder.sv
// One accumulate lane: modulo add, or signed saturating add when NMC_ACC_SATURATE_EN is defined.
module nmc_lane_adder
    import nmc_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
`ifdef NMC_ACC_SATURATE_EN
    output logic [LANE_W-1:0] sum,
    output logic              sat
`else
    output logic [LANE_W-1:0] sum
`endif
);
`ifdef NMC_ACC_SATURATE_EN
    logic [LANE_W-1:0] raw;
    logic              ovf;

    always_comb begin
        raw = a + b;
        ovf = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
        sat = ovf;
        if (!ovf)
            sum = raw;
        else if (a[LANE_W-1])
            sum = {1'b1, {(LANE_W-1){1'b0}}};
        else
            sum = {1'b0, {(LANE_W-1){1'b1}}};
    end
`else
    always_comb begin
        sum = a + b;
    end
`endif
endmodule

// File: rtl/nmc_sram_arbiter.sv
// Two-requester round-robin SRAM arbiter with lock and read-modify-write accumulate.
// Optional macro NMC_ACC_SATURATE_EN selects saturating lanes and adds acc_sat_o.
module nmc_sram_arbiter
    import nmc_pkg::*;
#(
    parameter int DATA_W  = NUM_LANES * LANE_W_DEF,
    parameter int LANE_W  = LANE_W_DEF,
    parameter int SRAM_AW = 9
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [63:0]         avs0_address,
    input  logic                avs0_read,
    input  logic                avs0_write,
    input  logic [DATA_W/8-1:0] avs0_byteenable,
    input  logic [DATA_W-1:0]   avs0_writedata,
    input  logic                avs0_lock,
    output logic [DATA_W-1:0]   avs0_readdata,
    output logic                avs0_waitrequest,
    input  logic [63:0]         avs1_address,
    input  logic                avs1_read,
    input  logic                avs1_write,
    input  logic [DATA_W/8-1:0] avs1_byteenable,
    input  logic [DATA_W-1:0]   avs1_writedata,
    input  logic                avs1_lock,
    output logic [DATA_W-1:0]   avs1_readdata,
    output logic                avs1_waitrequest,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W/8-1:0] sram_byteenable,
    output logic [DATA_W-1:0]   sram_writedata,
    output logic                sram_wren,
`ifdef NMC_ACC_SATURATE_EN
    input  logic [DATA_W-1:0]   sram_readdata,
    output logic                acc_sat_o
`else
    input  logic [DATA_W-1:0]   sram_readdata
`endif
);
    localparam int NLANES = DATA_W / LANE_W;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                rr_last_q, rr_last_d;
    logic                lock_valid_q, lock_valid_d;
    logic                lock_owner_q, lock_owner_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   acc_q, acc_d;

    logic [63:0]         addr_in [NUM_REQ];
    logic [DATA_W-1:0]   wd_in   [NUM_REQ];
    logic [DATA_W/8-1:0] be_in   [NUM_REQ];
    logic [DATA_W-1:0]   rdata   [NUM_REQ];
    logic [NUM_REQ-1:0]  rd_in, wr_in, lock_in, req, elig, waitreq;
    logic                win, any_req, complete, cidx;
    logic [DATA_W-1:0]   acc_sum;
    logic                unused_addr_bits;

    assign addr_in[0] = avs0_address;
    assign addr_in[1] = avs1_address;
    assign wd_in[0]   = avs0_writedata;
    assign wd_in[1]   = avs1_writedata;
    assign be_in[0]   = avs0_byteenable;
    assign be_in[1]   = avs1_byteenable;
    assign rd_in      = {avs1_read, avs0_read};
    assign wr_in      = {avs1_write, avs0_write};
    assign lock_in    = {avs1_lock, avs0_lock};

    assign avs0_readdata    = rdata[0];
    assign avs1_readdata    = rdata[1];
    assign avs0_waitrequest = waitreq[0];
    assign avs1_waitrequest = waitreq[1];

    assign unused_addr_bits = ^{avs0_address[ACC_FLAG_BIT-1:SRAM_AW],
                                avs1_address[ACC_FLAG_BIT-1:SRAM_AW]};

`ifdef NMC_ACC_SATURATE_EN
    logic [NLANES-1:0] lane_sat;
    logic              sat_q, sat_d;
    assign acc_sat_o = sat_q;
`endif

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        nmc_lane_adder #(.LANE_W(LANE_W)) u_lane (
            .a   (wdata_q[i*LANE_W +: LANE_W]),
            .b   (acc_q[i*LANE_W +: LANE_W]),
`ifdef NMC_ACC_SATURATE_EN
            .sum (acc_sum[i*LANE_W +: LANE_W]),
            .sat (lane_sat[i])
`else
            .sum (acc_sum[i*LANE_W +: LANE_W])
`endif
        );
    end

    always_comb begin
        req     = rd_in | wr_in;
        elig[0] = req[0] && (!lock_valid_q || !lock_owner_q);
        elig[1] = req[1] && (!lock_valid_q ||  lock_owner_q);
        any_req = |elig;
        win     = (elig[0] && elig[1]) ? ~rr_last_q : elig[1];

        state_d      = state_q;
        grant_d      = grant_q;
        rr_last_d    = rr_last_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        acc_d        = acc_q;
        complete     = 1'b0;
        waitreq      = '1;
        rdata[0]     = '0;
        rdata[1]     = '0;
        sram_addr       = addr_q;
        sram_wren       = 1'b0;
        sram_byteenable = '0;
        sram_writedata  = wdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d   = win;
                    addr_d    = addr_in[win][SRAM_AW-1:0];
                    wdata_d   = wd_in[win];
                    be_d      = be_in[win];
                    sram_addr = addr_in[win][SRAM_AW-1:0];
                    // A write wins over a simultaneous read from the same master.
                    if (wr_in[win]) begin
                        if (addr_in[win][ACC_FLAG_BIT]) begin
                            state_d = ACC_RD;
                        end else begin
                            sram_wren       = 1'b1;
                            sram_byteenable = be_in[win];
                            sram_writedata  = wd_in[win];
                            waitreq[win]    = 1'b0;
                            complete        = 1'b1;
                        end
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                waitreq[grant_q] = 1'b0;
                rdata[grant_q]   = sram_readdata;
                complete         = 1'b1;
                state_d          = IDLE;
            end
            ACC_RD: begin
                acc_d   = sram_readdata;
                state_d = ACC_WR;
            end
            ACC_WR: begin
                sram_wren        = 1'b1;
                sram_byteenable  = be_q;
                sram_writedata   = acc_sum;
                waitreq[grant_q] = 1'b0;
                complete         = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cidx = (state_q == IDLE) ? win : grant_q;
        if (complete) begin
            rr_last_d    = cidx;
            lock_valid_d = lock_in[cidx];
            lock_owner_d = cidx;
        end
    end

`ifdef NMC_ACC_SATURATE_EN
    always_comb begin
        sat_d = sat_q | ((state_q == ACC_WR) && (|lane_sat));
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            acc_q        <= '0;
`ifdef NMC_ACC_SATURATE_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_last_q    <= rr_last_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            acc_q        <= acc_d;
`ifdef NMC_ACC_SATURATE_EN
            sat_q        <= sat_d;
`endif
        end
    end
endmodule

// File: tb/tb_nmc_sram_arbiter.sv
// Directed bench for nmc_sram_arbiter with a behavioural 1-cycle SRAM model.
module tb_nmc_sram_arbiter;
    logic         clk;
    logic         rstn;
    logic [63:0]  a0_addr, a1_addr;
    logic         a0_rd, a0_wr, a1_rd, a1_wr, a0_lk, a1_lk;
    logic [63:0]  a0_be, a1_be;
    logic [511:0] a0_wd, a1_wd;
    logic [511:0] a0_rdata, a1_rdata;
    logic         a0_wait, a1_wait;
    logic [8:0]   sram_addr;
    logic [63:0]  sram_be;
    logic [511:0] sram_wd;
    logic         sram_wren;
    logic [511:0] sram_rd;
`ifdef NMC_ACC_SATURATE_EN
    logic         acc_sat;
`endif

    logic [511:0] mem [512];
    int           total = 0;
    int           bad   = 0;

    logic [511:0] pat_a5, pat_10, pat_15, pat_5, pat_1, wbase, wres, wread, pat_11, pat_22;
    logic [63:0]  be_all, be_mask;

    nmc_sram_arbiter #(.DATA_W(512), .LANE_W(32), .SRAM_AW(9)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .avs0_address     (a0_addr),
        .avs0_read        (a0_rd),
        .avs0_write       (a0_wr),
        .avs0_byteenable  (a0_be),
        .avs0_writedata   (a0_wd),
        .avs0_lock        (a0_lk),
        .avs0_readdata    (a0_rdata),
        .avs0_waitrequest (a0_wait),
        .avs1_address     (a1_addr),
        .avs1_read        (a1_rd),
        .avs1_write       (a1_wr),
        .avs1_byteenable  (a1_be),
        .avs1_writedata   (a1_wd),
        .avs1_lock        (a1_lk),
        .avs1_readdata    (a1_rdata),
        .avs1_waitrequest (a1_wait),
        .sram_addr        (sram_addr),
        .sram_byteenable  (sram_be),
        .sram_writedata   (sram_wd),
        .sram_wren        (sram_wren),
`ifdef NMC_ACC_SATURATE_EN
        .sram_readdata    (sram_rd),
        .acc_sat_o        (acc_sat)
`else
        .sram_readdata    (sram_rd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_wren)
            for (int b = 0; b < 64; b++)
                if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wd[b*8 +: 8];
        sram_rd <= mem[sram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [63:0] ad,
                        input logic [63:0] be, input logic [511:0] wd, input logic lk);
        a0_rd = rd; a0_wr = wr; a0_addr = ad; a0_be = be; a0_wd = wd; a0_lk = lk;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [63:0] ad,
                        input logic [63:0] be, input logic [511:0] wd, input logic lk);
        a1_rd = rd; a1_wr = wr; a1_addr = ad; a1_be = be; a1_wd = wd; a1_lk = lk;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        pat_a5  = {64{8'hA5}};
        pat_10  = {16{32'h0000_0010}};
        pat_15  = {16{32'h0000_0015}};
        pat_5   = {16{32'h0000_0005}};
        pat_1   = {16{32'h0000_0001}};
        pat_11  = {64{8'h11}};
        pat_22  = {64{8'h22}};
        be_all  = 64'hFFFF_FFFF_FFFF_FFFF;
        be_mask = 64'hFFFF_FFFF_FFFF_FFF0;
`ifdef NMC_ACC_SATURATE_EN
        wbase = {16{32'h7FFF_FFFF}};
        wres  = {16{32'h7FFF_FFFF}};
`else
        wbase = {16{32'hFFFF_FFFF}};
        wres  = '0;
`endif
        wread = {wres[511:32], wbase[31:0]};

        rstn = 1'b0;
        drv0(0, 0, 64'd0, 64'd0, '0, 0);
        drv1(0, 0, 64'd0, 64'd0, '0, 0);
        step(); step();
        mid();
        chk("rst_wait0", 64'(a0_wait), 64'd1);
        chk("rst_wait1", 64'(a1_wait), 64'd1);
        chk("rst_wren", 64'(sram_wren), 64'd0);
        chk("rst_be", sram_be, 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chkw("rst_rdata0", a0_rdata, '0);
        chkw("rst_rdata1", a1_rdata, '0);
`ifdef NMC_ACC_SATURATE_EN
        chk("rst_sat", 64'(acc_sat), 64'd0);
`endif
        step();
        rstn = 1'b1;

        // single write, zero wait states
        drv0(0, 1, 64'd5, be_all, pat_a5, 0);
        mid();
        chk("wr_wren", 64'(sram_wren), 64'd1);
        chk("wr_wait0", 64'(a0_wait), 64'd0);
        chk("wr_wait1", 64'(a1_wait), 64'd1);
        chk("wr_addr", 64'(sram_addr), 64'd5);
        chk("wr_be", sram_be, be_all);
        chkw("wr_data", sram_wd, pat_a5);
        step();
        drv0(0, 0, 64'd0, 64'd0, '0, 0);

        // read from requester 1, one stall cycle
        drv1(1, 0, 64'd5, 64'd0, '0, 0);
        mid();
        chk("rd_wait_c1", 64'(a1_wait), 64'd1);
        chk("rd_addr", 64'(sram_addr), 64'd5);
        chk("rd_wren", 64'(sram_wren), 64'd0);
        step(); mid();
        chk("rd_wait_c2", 64'(a1_wait), 64'd0);
        chkw("rd_data", a1_rdata, pat_a5);
        step();
        drv1(0, 0, 64'd0, 64'd0, '0, 0);

        // accumulate 0x10 + 0x5 per lane at address 3
        drv0(0, 1, 64'd3, be_all, pat_10, 0);
        step();
        drv0(0, 1, {1'b1, 63'd3}, be_all, pat_5, 0);
        mid();
        chk("acc_c1_wait", 64'(a0_wait), 64'd1);
        chk("acc_c1_wren", 64'(sram_wren), 64'd0);
        chk("acc_c1_addr", 64'(sram_addr), 64'd3);
        step(); mid();
        chk("acc_c2_wait", 64'(a0_wait), 64'd1);
        chk("acc_c2_wren", 64'(sram_wren), 64'd0);
        step(); mid();
        chk("acc_c3_wait", 64'(a0_wait), 64'd0);
        chk("acc_c3_wren", 64'(sram_wren), 64'd1);
        chk("acc_c3_addr", 64'(sram_addr), 64'd3);
        chkw("acc_c3_data", sram_wd, pat_15);
        step();
        drv0(0, 0, 64'd0, 64'd0, '0, 0);
        drv0(1, 0, 64'd3, 64'd0, '0, 0);
        step(); mid();
        chkw("acc_readback", a0_rdata, pat_15);
`ifdef NMC_ACC_SATURATE_EN
        chk("acc_sat_clear", 64'(acc_sat), 64'd0);
`endif
        step();
        drv0(0, 0, 64'd0, 64'd0, '0, 0);

        // lane overflow with lane 0 byte-disabled
        drv0(0, 1, 64'd7, be_all, wbase, 0);
        step();
        drv0(0, 1, {1'b1, 63'd7}, be_mask, pat_1, 0);
        step(); step(); mid();
        chkw("wrap_data", sram_wd, wres);
        chk("wrap_be", sram_be, be_mask);
        step();
        drv0(0, 0, 64'd0, 64'd0, '0, 0);
        drv1(1, 0, 64'd7, 64'd0, '0, 0);
        step(); mid();
        chkw("wrap_readback", a1_rdata, wread);
`ifdef NMC_ACC_SATURATE_EN
        chk("wrap_sat", 64'(acc_sat), 64'd1);
`endif
        step();
        drv1(0, 0, 64'd0, 64'd0, '0, 0);

        // contention: continuous reads alternate starting with requester 0
        drv0(1, 0, 64'd5, 64'd0, '0, 0);
        drv1(1, 0, 64'd3, 64'd0, '0, 0);
        for (int k = 0; k < 20; k++) begin
            mid();
            chk("cont_idle_wait", 64'({a1_wait, a0_wait}), 64'd3);
            step(); mid();
            if (k % 2 == 0) begin
                chk("cont_wait_g0", 64'({a1_wait, a0_wait}), 64'd2);
                chkw("cont_data0", a0_rdata, pat_a5);
            end else begin
                chk("cont_wait_g1", 64'({a1_wait, a0_wait}), 64'd1);
                chkw("cont_data1", a1_rdata, pat_15);
            end
            step();
        end
        drv0(0, 0, 64'd0, 64'd0, '0, 0);
        drv1(0, 0, 64'd0, 64'd0, '0, 0);

        // lock: requester 1 holds the SRAM across three writes
        drv1(0, 1, 64'd10, be_all, pat_11, 1);
        mid();
        chk("lk1_wait1", 64'(a1_wait), 64'd0);
        step();
        drv1(0, 0, 64'd0, 64'd0, '0, 0);
        drv0(0, 1, 64'd11, be_all, pat_22, 0);
        mid();
        chk("lk_idle_wait0", 64'(a0_wait), 64'd1);
        chk("lk_idle_wren", 64'(sram_wren), 64'd0);
        step();
        drv1(0, 1, 64'd12, be_all, pat_11, 1);
        mid();
        chk("lk2_wait", 64'({a1_wait, a0_wait}), 64'd1);
        chk("lk2_addr", 64'(sram_addr), 64'd12);
        step();
        drv1(0, 1, 64'd13, be_all, pat_11, 0);
        mid();
        chk("lk3_wait", 64'({a1_wait, a0_wait}), 64'd1);
        chk("lk3_addr", 64'(sram_addr), 64'd13);
        step();
        drv1(0, 0, 64'd0, 64'd0, '0, 0);
        mid();
        chk("lk_rel_wait0", 64'(a0_wait), 64'd0);
        chk("lk_rel_addr", 64'(sram_addr), 64'd11);
        step();
        drv0(0, 0, 64'd0, 64'd0, '0, 0);

        // reset during ACC_RD
        drv0(0, 1, {1'b1, 63'd3}, be_all, pat_1, 0);
        step();
        rstn = 1'b0;
        drv1(1, 0, 64'd5, 64'd0, '0, 0);
        mid();
        chk("mrst_wren", 64'(sram_wren), 64'd0);
        chk("mrst_wait", 64'({a1_wait, a0_wait}), 64'd3);
        chk("mrst_be", sram_be, 64'd0);
        step(); mid();
        chk("mrst_wren2", 64'(sram_wren), 64'd0);
        step();
        drv0(0, 0, 64'd0, 64'd0, '0, 0);
        drv1(0, 0, 64'd0, 64'd0, '0, 0);
        rstn = 1'b1;
        drv0(1, 0, 64'd3, 64'd0, '0, 0);
        drv1(1, 0, 64'd5, 64'd0, '0, 0);
        mid();
        chk("post_rst_addr", 64'(sram_addr), 64'd3);
        step(); mid();
        chk("post_rst_wait", 64'({a1_wait, a0_wait}), 64'd2);
        chkw("post_rst_data", a0_rdata, pat_15);
        step();
        drv0(0, 0, 64'd0, 64'd0, '0, 0);
        drv1(0, 0, 64'd0, 64'd0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
